pulse_meter: RTL and testbench
==============================

PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, giving the consecutive equal samples needed to accept a level change (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the pulse counter and width counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port sig_syn  in  1  already-synchronized input from the 3-flop synchronizer stage.
REQ-006 SHALL have port clr  in  1  synchronous clear of counters and flags.
REQ-007 SHALL have port sig_db  out  1  debounced level.
REQ-008 SHALL have ports rise_p and fall_p  out  1 each  single-cycle edge pulses of sig_db.
REQ-009 SHALL have port pulse_cnt  out  CNT_W  count of accepted rising edges.
REQ-010 SHALL have port ovf  out  1  sticky flag for pulse_cnt saturation.
REQ-011 SHALL have port width_last  out  CNT_W  high time of the last completed pulse, in clk cycles.
REQ-012 SHALL have port width_vld  out  1  single-cycle strobe when width_last updates.

Function
REQ-013 SHALL implement the FSM states LOW, DEB_H, HIGH and DEB_L; sig_db SHALL be 0 in LOW and DEB_H and 1 in HIGH and DEB_L.
REQ-014 In LOW with sig_syn=1, the FSM SHALL go to DEB_H with debounce count=1; in HIGH with sig_syn=0, it SHALL go to DEB_L with count=1.
REQ-015 In DEB_H with sig_syn=0, the FSM SHALL return to LOW (and in DEB_L with sig_syn=1, to HIGH) with no edge reported and the count cleared.
REQ-016 On the DEB_CYCLES-th consecutive new-level sample, the FSM SHALL enter HIGH (or LOW), register sig_db to the new level, and assert rise_p (or fall_p) for exactly one cycle, aligned with the sig_db change.
REQ-017 With DEB_CYCLES=1, the FSM SHALL bypass DEB_H/DEB_L, and sig_db SHALL equal sig_syn delayed by one cycle.
REQ-018 pulse_cnt SHALL increment on the same edge that asserts rise_p, SHALL saturate at 2^CNT_W-1, and ovf SHALL set on the first rise_p while saturated and remain set.
REQ-019 The width counter SHALL load 1 on the rise_p edge and increment each cycle while sig_db=1, saturating at 2^CNT_W-1.
REQ-020 On the fall_p edge, width_last SHALL load the width counter value and width_vld SHALL assert for one cycle; width_last SHALL hold otherwise.
REQ-021 clr=1 SHALL zero pulse_cnt, ovf, width_last and width_vld on the next edge without altering the FSM or sig_db.
REQ-022 When clr coincides with rise_p, clr SHALL win: pulse_cnt=0 and the edge is not counted, while the width measurement still starts.
REQ-023 When clr coincides with fall_p, clr SHALL win: width_last=0 and width_vld=0.
REQ-024 rise_p and fall_p SHALL never be asserted in the same cycle.

Reset
REQ-025 rst=1 SHALL force state LOW, debounce count 0, sig_db=0, rise_p=0, fall_p=0, pulse_cnt=0, ovf=0, the width counter 0, width_last=0 and width_vld=0 on the next posedge clk.
REQ-026 rst SHALL dominate clr and all input activity; reset mid-pulse SHALL discard the pulse with no fall_p and no width_vld.
REQ-027 After rst deasserts with sig_syn=1, the FSM SHALL debounce from LOW and report a rising edge after DEB_CYCLES samples.

Configuration
REQ-028 With macro PULSE_METER_WIDTH_EN defined, the block SHALL include the width counter, width_last and width_vld per REQ-019..020.
REQ-029 Without PULSE_METER_WIDTH_EN, the block SHALL omit the width counter, tie width_last to 0 and width_vld to 0, and leave all other behaviour unchanged.

Verification
REQ-030 The bench SHALL cover: DEB_CYCLES=4, sig_syn 0->1 held 10 cycles -> rise_p one cycle after the 4th high sample, sig_db=1, pulse_cnt=1.
REQ-031 The bench SHALL cover: glitch high for 3 cycles then low -> no rise_p, sig_db stays 0, pulse_cnt unchanged.
REQ-032 The bench SHALL cover: with PULSE_METER_WIDTH_EN, sig_syn high 20 cycles then low 10 -> fall_p and width_vld together, width_last=20.
REQ-033 The bench SHALL cover: CNT_W=4, 17 clean pulses -> pulse_cnt=15, ovf=1 from the 16th pulse; then clr -> pulse_cnt=0, ovf=0.
REQ-034 The bench SHALL cover: clr asserted on the rise_p cycle -> pulse_cnt=0 and the next pulse gives pulse_cnt=1.
REQ-035 The bench SHALL cover: rst asserted while in HIGH -> next cycle sig_db=0, all outputs 0, and no fall_p or width_vld ever generated for that pulse.

Source files
------------

// File: rtl/pulse_meter.sv
// pulse_meter
//   Debounces an already-synchronized level, reports single-cycle edge pulses,
//   counts accepted rising edges (saturating, with sticky overflow) and
//   optionally measures the high time of each completed pulse.
//
// Parameters
//   DEB_CYCLES  consecutive equal samples needed to accept a level change (1..15)
//   CNT_W       width of the pulse counter and the width counter
//
// Ports
//   clk         sole clock, all state updates on its rising edge
//   rst         synchronous active-high reset
//   sig_syn     synchronized input level
//   clr         synchronous clear of counters and flags (FSM untouched)
//   sig_db      debounced level
//   rise_p      one-cycle pulse on an accepted rising edge of sig_db
//   fall_p      one-cycle pulse on an accepted falling edge of sig_db
//   pulse_cnt   accepted rising edges, saturating at 2^CNT_W-1
//   ovf         sticky: a rising edge arrived while pulse_cnt was saturated
//   width_last  high time of the last completed pulse, in clk cycles
//   width_vld   one-cycle strobe when width_last updates
//
// Build option
//   PULSE_METER_WIDTH_EN  when defined, the width measurement is built;
//                         otherwise width_last and width_vld are tied to 0.

module pulse_meter #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_syn,
    input  logic             clr,
    output logic             sig_db,
    output logic             rise_p,
    output logic             fall_p,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             ovf,
    output logic [CNT_W-1:0] width_last,
    output logic             width_vld
);

    typedef enum logic [1:0] {LOW, DEB_H, HIGH, DEB_L} state_t;

    localparam logic [3:0]       DEB_LAST = 4'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       deb_q, deb_d;
    logic             sig_db_q, sig_db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             ovf_q, ovf_d;

    // deb_q holds how many new-level samples have been seen so far; the
    // DEB_CYCLES-th one commits the edge.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW: begin
                if (sig_syn) begin
                    if (DEB_CYCLES == 1) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = DEB_H;
                        deb_d   = 4'd1;
                    end
                end
            end
            DEB_H: begin
                if (!sig_syn) begin
                    state_d = LOW;
                    deb_d   = 4'd0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = HIGH;
                    deb_d   = 4'd0;
                    rise_d  = 1'b1;
                end else begin
                    deb_d = deb_q + 4'd1;
                end
            end
            HIGH: begin
                if (!sig_syn) begin
                    if (DEB_CYCLES == 1) begin
                        state_d = LOW;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = DEB_L;
                        deb_d   = 4'd1;
                    end
                end
            end
            DEB_L: begin
                if (sig_syn) begin
                    state_d = HIGH;
                    deb_d   = 4'd0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = LOW;
                    deb_d   = 4'd0;
                    fall_d  = 1'b1;
                end else begin
                    deb_d = deb_q + 4'd1;
                end
            end
            default: begin
                state_d = LOW;
                deb_d   = 4'd0;
            end
        endcase
    end

    // The debounced level is a pure decode of the next state, registered so
    // that it changes on the same edge as rise_p/fall_p.
    assign sig_db_d = (state_d == HIGH) || (state_d == DEB_L);

    // clr has priority over a coincident rising edge: the edge is not counted.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        ovf_d       = ovf_q;
        if (clr) begin
            pulse_cnt_d = '0;
            ovf_d       = 1'b0;
        end else if (rise_d) begin
            if (pulse_cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end
            pulse_cnt_d = sat_inc(pulse_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOW;
            deb_q       <= 4'd0;
            sig_db_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            pulse_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            sig_db_q    <= sig_db_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            pulse_cnt_q <= pulse_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign sig_db    = sig_db_q;
    assign rise_p    = rise_q;
    assign fall_p    = fall_q;
    assign pulse_cnt = pulse_cnt_q;
    assign ovf       = ovf_q;

`ifdef PULSE_METER_WIDTH_EN
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] width_last_q, width_last_d;
    logic             width_vld_q, width_vld_d;

    // The running width starts at 1 on the rising edge and grows every cycle
    // sig_db is high; on the falling edge its value equals the high time.
    // clr does not touch the running width, so a measurement started on a
    // cleared rising edge still completes.
    always_comb begin
        width_d      = width_q;
        width_last_d = width_last_q;
        width_vld_d  = 1'b0;
        if (rise_d) begin
            width_d = CNT_ONE;
        end else if (sig_db_q) begin
            width_d = sat_inc(width_q);
        end
        if (clr) begin
            width_last_d = '0;
        end else if (fall_d) begin
            width_last_d = width_q;
            width_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_q      <= '0;
            width_last_q <= '0;
            width_vld_q  <= 1'b0;
        end else begin
            width_q      <= width_d;
            width_last_q <= width_last_d;
            width_vld_q  <= width_vld_d;
        end
    end

    assign width_last = width_last_q;
    assign width_vld  = width_vld_q;
`else
    assign width_last = '0;
    assign width_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter. Three instances share the stimulus:
// u8 (DEB_CYCLES=4, CNT_W=8), u4 (DEB_CYCLES=4, CNT_W=4), u1 (DEB_CYCLES=1).
// Expected pulse counts and widths for u8 are queued when a pulse is driven
// and popped when u8 reports rise_p / width_vld.

module tb_pulse_meter;

`ifdef PULSE_METER_WIDTH_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, sig_syn, clr;

    logic       db8, r8, f8, ovf8, wv8;
    logic [7:0] cnt8, wl8;
    logic       db4, r4, f4, ovf4, wv4;
    logic [3:0] cnt4, wl4;
    logic       db1, r1, f1, ovf1, wv1;
    logic [7:0] cnt1, wl1;

    int errors = 0;
    int checks = 0;
    logic [7:0] q_cnt[$];
    logic [7:0] q_w[$];
    logic [7:0] mon_v;
    int exp_cnt8;

    always #5 clk = ~clk;

    pulse_meter #(.DEB_CYCLES(4), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .sig_syn(sig_syn), .clr(clr),
        .sig_db(db8), .rise_p(r8), .fall_p(f8), .pulse_cnt(cnt8), .ovf(ovf8),
        .width_last(wl8), .width_vld(wv8));

    pulse_meter #(.DEB_CYCLES(4), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .sig_syn(sig_syn), .clr(clr),
        .sig_db(db4), .rise_p(r4), .fall_p(f4), .pulse_cnt(cnt4), .ovf(ovf4),
        .width_last(wl4), .width_vld(wv4));

    pulse_meter #(.DEB_CYCLES(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .sig_syn(sig_syn), .clr(clr),
        .sig_db(db1), .rise_p(r1), .fall_p(f1), .pulse_cnt(cnt1), .ovf(ovf1),
        .width_last(wl1), .width_vld(wv1));

    // Scoreboard side: compare u8 events against the queued expectations.
    always @(negedge clk) begin
        checks++;
        if (r8 === 1'b1 && f8 === 1'b1) begin
            errors++;
            $display("FAIL edge_exclusive rise_p=%b fall_p=%b required not both", r8, f8);
        end
        if (r8 === 1'b1) begin
            checks++;
            if (q_cnt.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rise pulse_cnt=%0d required no rise_p", cnt8);
            end else begin
                mon_v = q_cnt.pop_front();
                if (cnt8 !== mon_v) begin
                    errors++;
                    $display("FAIL rise_count pulse_cnt=%0d required %0d", cnt8, mon_v);
                end
            end
        end
        if (wv8 === 1'b1) begin
            checks++;
            if (q_w.size() == 0) begin
                errors++;
                $display("FAIL unexpected_width_vld width_last=%0d required no width_vld", wl8);
            end else begin
                mon_v = q_w.pop_front();
                if (wl8 !== mon_v || f8 !== 1'b1) begin
                    errors++;
                    $display("FAIL width_event width_last=%0d fall_p=%b required %0d and 1",
                             wl8, f8, mon_v);
                end
            end
        end
    end

    task automatic pulse(input int hi, input int lo);
        exp_cnt8 = exp_cnt8 + 1;
        q_cnt.push_back(8'(exp_cnt8));
        if (WEN) q_w.push_back(8'(hi));
        sig_syn = 1'b1;
        repeat (hi) @(negedge clk);
        sig_syn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b1; sig_syn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({db8, r8, f8, ovf8, wv8, cnt8, wl8} !== 21'd0) begin
            errors++;
            $display("FAIL reset_u8 outputs=%h required 0", {db8, r8, f8, ovf8, wv8, cnt8, wl8});
        end
        checks++;
        if ({db4, r4, f4, ovf4, wv4, cnt4, wl4} !== 13'd0) begin
            errors++;
            $display("FAIL reset_u4 outputs=%h required 0", {db4, r4, f4, ovf4, wv4, cnt4, wl4});
        end
        checks++;
        if ({db1, r1, f1, ovf1, wv1, cnt1, wl1} !== 21'd0) begin
            errors++;
            $display("FAIL reset_u1 outputs=%h required 0", {db1, r1, f1, ovf1, wv1, cnt1, wl1});
        end
        rst = 1'b0; clr = 1'b0; sig_syn = 1'b0;
        exp_cnt8 = 0;
        @(negedge clk);
    endtask

    task automatic test_rise;
        exp_cnt8 = 1;
        q_cnt.push_back(8'd1);
        if (WEN) q_w.push_back(8'd10);
        sig_syn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (r8 !== (i == 4) || db8 !== (i >= 4)) begin
                errors++;
                $display("FAIL rise_timing cycle=%0d rise_p=%b sig_db=%b required %b %b",
                         i, r8, db8, i == 4, i >= 4);
            end
            checks++;
            if (r1 !== (i == 1) || db1 !== 1'b1) begin
                errors++;
                $display("FAIL bypass_rise cycle=%0d rise_p=%b sig_db=%b required %b 1",
                         i, r1, db1, i == 1);
            end
        end
        checks++;
        if (cnt8 !== 8'd1 || cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL rise_count_held u8=%0d u4=%0d required 1 1", cnt8, cnt4);
        end
        sig_syn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (f8 !== (i == 4) || db8 !== (i < 4) || wv8 !== (WEN && i == 4)) begin
                errors++;
                $display("FAIL fall_timing cycle=%0d fall_p=%b sig_db=%b width_vld=%b required %b %b %b",
                         i, f8, db8, wv8, i == 4, i < 4, WEN && i == 4);
            end
            checks++;
            if (f1 !== (i == 1) || db1 !== 1'b0) begin
                errors++;
                $display("FAIL bypass_fall cycle=%0d fall_p=%b sig_db=%b required %b 0",
                         i, f1, db1, i == 1);
            end
        end
        checks++;
        if (wl8 !== (WEN ? 8'd10 : 8'd0) || wl1 !== (WEN ? 8'd10 : 8'd0)) begin
            errors++;
            $display("FAIL width_10 u8=%0d u1=%0d required %0d", wl8, wl1, WEN ? 10 : 0);
        end
    endtask

    task automatic test_glitch;
        sig_syn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) sig_syn = 1'b0;
            @(negedge clk);
            checks++;
            if (r8 !== 1'b0 || db8 !== 1'b0) begin
                errors++;
                $display("FAIL glitch cycle=%0d rise_p=%b sig_db=%b required 0 0", i, r8, db8);
            end
        end
        checks++;
        if (cnt8 !== 8'd1 || cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL glitch_count u8=%0d u4=%0d required 1 1", cnt8, cnt4);
        end
    endtask

    task automatic test_width;
        pulse(20, 10);
        checks++;
        if (wl8 !== (WEN ? 8'd20 : 8'd0) || wv8 !== 1'b0 || cnt8 !== 8'd2) begin
            errors++;
            $display("FAIL width_20 width_last=%0d width_vld=%b pulse_cnt=%0d required %0d 0 2",
                     wl8, wv8, cnt8, WEN ? 20 : 0);
        end
    endtask

    task automatic test_overflow;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_cnt8 = 0;
        checks++;
        if (cnt4 !== 4'd0 || ovf4 !== 1'b0 || cnt8 !== 8'd0 || wl8 !== 8'd0) begin
            errors++;
            $display("FAIL clr_before_ovf u4=%0d ovf=%b u8=%0d width_last=%0d required 0 0 0 0",
                     cnt4, ovf4, cnt8, wl8);
        end
        for (int k = 1; k <= 17; k++) begin
            int e;
            e = (k < 15) ? k : 15;
            pulse(5, 5);
            checks++;
            if (cnt4 !== e[3:0] || ovf4 !== (k >= 16)) begin
                errors++;
                $display("FAIL saturate pulse=%0d pulse_cnt=%0d ovf=%b required %0d %b",
                         k, cnt4, ovf4, e, k >= 16);
            end
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_cnt8 = 0;
        checks++;
        if (cnt4 !== 4'd0 || ovf4 !== 1'b0 || cnt8 !== 8'd0 || wl8 !== 8'd0 || db8 !== 1'b0) begin
            errors++;
            $display("FAIL clr_after_ovf u4=%0d ovf=%b u8=%0d width_last=%0d sig_db=%b required 0",
                     cnt4, ovf4, cnt8, wl8, db8);
        end
    endtask

    task automatic test_clr_edges;
        q_cnt.push_back(8'd0);
        if (WEN) q_w.push_back(8'd8);
        sig_syn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 3) clr = 1'b1;
            if (i == 4) begin
                clr = 1'b0;
                checks++;
                if (r8 !== 1'b1 || cnt8 !== 8'd0 || cnt4 !== 4'd0 || db8 !== 1'b1) begin
                    errors++;
                    $display("FAIL clr_on_rise rise_p=%b u8=%0d u4=%0d sig_db=%b required 1 0 0 1",
                             r8, cnt8, cnt4, db8);
                end
            end
        end
        sig_syn = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wl8 !== (WEN ? 8'd8 : 8'd0)) begin
            errors++;
            $display("FAIL width_after_clr_rise width_last=%0d required %0d", wl8, WEN ? 8 : 0);
        end
        exp_cnt8 = 1;
        q_cnt.push_back(8'd1);
        sig_syn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if (r8 !== 1'b1 || cnt8 !== 8'd1) begin
                    errors++;
                    $display("FAIL next_pulse rise_p=%b pulse_cnt=%0d required 1 1", r8, cnt8);
                end
            end
        end
        sig_syn = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) clr = 1'b1;
            if (i == 4) begin
                clr = 1'b0;
                checks++;
                if (f8 !== 1'b1 || wv8 !== 1'b0 || wl8 !== 8'd0 || cnt8 !== 8'd0) begin
                    errors++;
                    $display("FAIL clr_on_fall fall_p=%b width_vld=%b width_last=%0d pulse_cnt=%0d required 1 0 0 0",
                             f8, wv8, wl8, cnt8);
                end
            end
        end
        exp_cnt8 = 0;
    endtask

    task automatic test_reset_mid;
        exp_cnt8 = 1;
        q_cnt.push_back(8'd1);
        sig_syn = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (db8 !== 1'b1) begin
            errors++;
            $display("FAIL reach_high sig_db=%b required 1", db8);
        end
        rst = 1'b1; clr = 1'b1;
        @(negedge clk);
        checks++;
        if ({db8, r8, f8, ovf8, wv8, cnt8, wl8} !== 21'd0 || {db4, cnt4, ovf4} !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid outputs=%h u4=%h required 0",
                     {db8, r8, f8, ovf8, wv8, cnt8, wl8}, {db4, cnt4, ovf4});
        end
        rst = 1'b0; clr = 1'b0; sig_syn = 1'b0;
        exp_cnt8 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (f8 !== 1'b0 || wv8 !== 1'b0 || db8 !== 1'b0) begin
                errors++;
                $display("FAIL discarded_pulse cycle=%0d fall_p=%b width_vld=%b sig_db=%b required 0 0 0",
                         i, f8, wv8, db8);
            end
        end
        rst = 1'b1; sig_syn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt8 = 1;
        q_cnt.push_back(8'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (r8 !== (i == 4) || db8 !== (i >= 4)) begin
                errors++;
                $display("FAIL rise_after_reset cycle=%0d rise_p=%b sig_db=%b required %b %b",
                         i, r8, db8, i == 4, i >= 4);
            end
        end
        if (WEN) q_w.push_back(8'd6);
        sig_syn = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wl8 !== (WEN ? 8'd6 : 8'd0) || cnt8 !== 8'd1) begin
            errors++;
            $display("FAIL width_after_reset width_last=%0d pulse_cnt=%0d required %0d 1",
                     wl8, cnt8, WEN ? 6 : 0);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; sig_syn = 1'b0;
        exp_cnt8 = 0;
        test_reset();
        test_rise();
        test_glitch();
        test_width();
        test_overflow();
        test_clr_edges();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (q_cnt.size() != 0 || q_w.size() != 0) begin
            errors++;
            $display("FAIL pending_events rise_left=%0d width_left=%0d required 0 0",
                     q_cnt.size(), q_w.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
